// File: rtl/bus_owner_ctrl.sv
// bus_owner_ctrl: round-robin bus-ownership controller for NUM_CH requesters.
// Tracks IDLE / BUSY / ERROR. It grants one requester and latches its payload
// onto the bus until done_i. A programmable watchdog traps stalled
// transactions in a sticky ERROR state.
//
// Handshake: req_i[k] is a level request that the requester holds until it
// sees gnt_o[k]. gnt_o is a one-cycle pulse in the first BUSY cycle, while
// bus_valid_o stays high for the whole BUSY interval. done_i is a
// completion strobe that is only observed in BUSY; err_clr_i is only
// observed in ERROR.
module bus_owner_ctrl #(
  parameter int NUM_CH        = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int TO_WIDTH      = 8,
  parameter int ERR_CNT_WIDTH = 8,
  localparam int OW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            req_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_i,
  output logic [NUM_CH-1:0]            gnt_o,
  input  logic                         done_i,
  input  logic [TO_WIDTH-1:0]          timeout_i,
  input  logic                         err_clr_i,
  output logic                         bus_valid_o,
  output logic [DATA_WIDTH-1:0]        bus_data_o,
  output logic [OW-1:0]                owner_o,
  output logic [1:0]                   state_o,
  output logic                         err_o,
  output logic [ERR_CNT_WIDTH-1:0]     err_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  localparam logic [OW-1:0] LAST_CH = OW'(NUM_CH - 1);

  // Registered state and outputs
  state_t                     r_state;
  logic [OW-1:0]              r_last_owner;
  logic [OW-1:0]              r_owner;
  logic [DATA_WIDTH-1:0]      r_bus_data;
  logic [NUM_CH-1:0]          r_gnt;
  logic                       r_bus_valid;
  logic                       r_err;
  logic [TO_WIDTH-1:0]        r_cnt;
  logic [ERR_CNT_WIDTH-1:0]   r_err_cnt;

  // Next-state values
  state_t                     w_state_next;
  logic [OW-1:0]              w_last_owner_next;
  logic [OW-1:0]              w_owner_next;
  logic [DATA_WIDTH-1:0]      w_bus_data_next;
  logic [NUM_CH-1:0]          w_gnt_next;
  logic                       w_bus_valid_next;
  logic                       w_err_next;
  logic [TO_WIDTH-1:0]        w_cnt_next;
  logic [ERR_CNT_WIDTH-1:0]   w_err_cnt_next;

  // Arbiter and watchdog helpers
  logic                       w_found;
  logic [OW-1:0]              w_winner;
  logic [OW-1:0]              w_idx;
  logic [DATA_WIDTH-1:0]      w_winner_data;
  logic [TO_WIDTH:0]          w_cnt_plus1;
  logic                       w_to_hit;
  logic                       w_cnt_sat;
  logic                       w_err_cnt_sat;

  // Round-robin search starting just after the last owner, wrapping at NUM_CH-1
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = OW'((int'(r_last_owner) + 1 + i) % NUM_CH);
      if (!w_found && req_i[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // Payload slice of the arbitration winner
  always_comb begin
    w_winner_data = data_i[w_winner*DATA_WIDTH +: DATA_WIDTH];
  end

  // Watchdog compare: fires when the counter has reached timeout_i-1 or beyond,
  // so that lowering timeout_i mid-transaction takes effect at once
  always_comb begin
    w_cnt_plus1   = {1'b0, r_cnt} + 1'b1;
    w_to_hit      = (timeout_i != '0) && (w_cnt_plus1 >= {1'b0, timeout_i});
    w_cnt_sat     = (r_cnt == '1);
    w_err_cnt_sat = (r_err_cnt == '1);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state and next-output logic
  always_comb begin
    w_state_next      = r_state;
    w_last_owner_next = r_last_owner;
    w_owner_next      = r_owner;
    w_bus_data_next   = r_bus_data;
    w_gnt_next        = '0;
    w_bus_valid_next  = 1'b0;
    w_err_next        = 1'b0;
    w_cnt_next        = r_cnt;
    w_err_cnt_next    = r_err_cnt;

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_next           = ST_BUSY;
          w_owner_next           = w_winner;
          w_bus_data_next        = w_winner_data;
          w_gnt_next[w_winner]   = 1'b1;
          w_bus_valid_next       = 1'b1;
          w_cnt_next             = '0;
        end
      end

      ST_BUSY: begin
        if (done_i) begin
          // Completion has priority over a coincident timeout
          w_state_next      = ST_IDLE;
          w_last_owner_next = r_owner;
        end else if (w_to_hit) begin
          w_state_next      = ST_ERROR;
          w_last_owner_next = r_owner;
          w_err_next        = 1'b1;
          if (!w_err_cnt_sat) begin
            w_err_cnt_next = r_err_cnt + 1'b1;
          end
        end else begin
          w_bus_valid_next = 1'b1;
          // Saturate rather than wrap so a watchdog enabled late in a long
          // transaction still fires
          if (!w_cnt_sat) begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end

      ST_ERROR: begin
        if (err_clr_i) begin
          w_state_next = ST_IDLE;
        end else begin
          w_err_next = 1'b1;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_owner <= LAST_CH;
      r_owner      <= '0;
      r_bus_data   <= '0;
      r_gnt        <= '0;
      r_bus_valid  <= 1'b0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_last_owner <= w_last_owner_next;
      r_owner      <= w_owner_next;
      r_bus_data   <= w_bus_data_next;
      r_gnt        <= w_gnt_next;
      r_bus_valid  <= w_bus_valid_next;
      r_err        <= w_err_next;
      r_cnt        <= w_cnt_next;
      r_err_cnt    <= w_err_cnt_next;
    end
  end

  assign gnt_o       = r_gnt;
  assign bus_valid_o = r_bus_valid;
  assign bus_data_o  = r_bus_data;
  assign owner_o     = r_owner;
  assign state_o     = r_state;
  assign err_o       = r_err;
  assign err_cnt_o   = r_err_cnt;

endmodule

// File: tb/tb_bus_owner_ctrl.sv
// Testbench for bus_owner_ctrl: directed scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model of the controller.
module tb_bus_owner_ctrl;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int TOW = 8;
  localparam int ECW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [NCH-1:0]      req_i;
  logic [NCH*DW-1:0]   data_i;
  logic [NCH-1:0]      gnt_o;
  logic                done_i;
  logic [TOW-1:0]      timeout_i;
  logic                err_clr_i;
  logic                bus_valid_o;
  logic [DW-1:0]       bus_data_o;
  logic [1:0]          owner_o;
  logic [1:0]          state_o;
  logic                err_o;
  logic [ECW-1:0]      err_cnt_o;

  bus_owner_ctrl #(
    .NUM_CH(NCH), .DATA_WIDTH(DW), .TO_WIDTH(TOW), .ERR_CNT_WIDTH(ECW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .data_i(data_i), .gnt_o(gnt_o),
    .done_i(done_i), .timeout_i(timeout_i), .err_clr_i(err_clr_i),
    .bus_valid_o(bus_valid_o), .bus_data_o(bus_data_o), .owner_o(owner_o),
    .state_o(state_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Mode: 0 idle, 1 busy, 2 error
  int          m_mode;
  int          m_last;
  int          m_owner;
  logic [DW-1:0] m_data;
  int          m_gnt_ch;     // -1 when no grant pulse
  int          m_busy_len;   // cycles spent in the current transaction
  int          m_errs;

  function automatic void model_reset();
    m_mode = 0; m_last = NCH - 1; m_owner = 0; m_data = '0;
    m_gnt_ch = -1; m_busy_len = 0; m_errs = 0;
  endfunction

  function automatic void model_step();
    int to;
    m_gnt_ch = -1;
    if (!rst_n) begin
      model_reset();
      return;
    end
    to = int'(timeout_i);
    if (m_mode == 0) begin
      for (int k = 1; k <= NCH; k++) begin
        int c;
        c = (m_last + k) % NCH;
        if (req_i[c] && m_gnt_ch < 0) m_gnt_ch = c;
      end
      if (m_gnt_ch >= 0) begin
        m_mode = 1; m_owner = m_gnt_ch; m_busy_len = 1;
        m_data = DW'(data_i >> (m_gnt_ch * DW));
      end
    end else if (m_mode == 1) begin
      if (done_i) begin
        m_mode = 0; m_last = m_owner;
      end else if (to != 0 && m_busy_len >= to) begin
        m_mode = 2; m_last = m_owner;
        if (m_errs < (1 << ECW) - 1) m_errs++;
      end else begin
        m_busy_len++;
      end
    end else begin
      if (err_clr_i) m_mode = 0;
    end
  endfunction

  task automatic compare_all(input string tag);
    logic [NCH-1:0] eg;
    eg = '0;
    if (m_gnt_ch >= 0) eg[m_gnt_ch] = 1'b1;
    check({tag, ".state"},   64'(state_o),     64'(m_mode));
    check({tag, ".gnt"},     64'(gnt_o),       64'(eg));
    check({tag, ".valid"},   64'(bus_valid_o), 64'(m_mode == 1));
    check({tag, ".err"},     64'(err_o),       64'(m_mode == 2));
    check({tag, ".owner"},   64'(owner_o),     64'(m_owner));
    check({tag, ".data"},    64'(bus_data_o),  64'(m_data));
    check({tag, ".err_cnt"}, 64'(err_cnt_o),   64'(m_errs));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    compare_all(tag);
  endtask

  task automatic idle_inputs();
    req_i = '0; done_i = 1'b0; err_clr_i = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    int busy_cycles;
    int grants;
    model_reset();
    rst_n = 1'b0; idle_inputs(); timeout_i = '0;
    for (int k = 0; k < NCH; k++) data_i[k*DW +: DW] = DW'(32'h1000_0000 + k);
    tick("rst0");
    tick("rst1");
    check("rst.state", 64'(state_o), 64'd0);
    check("rst.err_cnt", 64'(err_cnt_o), 64'd0);
    rst_n = 1'b1;

    // Single request from ch0
    data_i[0 +: DW] = 32'hDEADBEEF;
    req_i = 4'b0001;
    tick("t1.grant");
    check("t1.gnt", 64'(gnt_o), 64'h1);
    check("t1.valid", 64'(bus_valid_o), 64'h1);
    check("t1.data", 64'(bus_data_o), 64'hDEADBEEF);
    check("t1.state", 64'(state_o), 64'h1);
    req_i = '0;
    tick("t1.busy");
    tick("t1.busy");
    done_i = 1'b1;
    tick("t1.done");
    check("t1.idle", 64'(state_o), 64'h0);
    check("t1.valid0", 64'(bus_valid_o), 64'h0);
    done_i = 1'b0;

    // All requesting: round-robin order 1,2,3,0,1 after ch0 was last owner
    exp_q = {2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    req_i = 4'b1111;
    grants = 0;
    for (int c = 0; c < 30 && grants < 5; c++) begin
      tick("t2");
      done_i = 1'b0;
      if (gnt_o != '0) begin
        logic [1:0] e;
        e = exp_q.pop_front();
        check("t2.order", 64'(gnt_o), 64'(1 << e));
        grants++;
        done_i = 1'b1;
      end
    end
    check("t2.grants", 64'(grants), 64'd5);
    tick("t2.last");
    check("t2.idle", 64'(state_o), 64'h0);
    idle_inputs();

    // Timeout of 4 on ch2
    timeout_i = 8'd4;
    data_i[2*DW +: DW] = 32'hCAFE0002;
    req_i = 4'b0100;
    tick("t3.grant");
    req_i = '0;
    busy_cycles = 0;
    for (int c = 0; c < 20 && state_o == 2'd1; c++) begin
      busy_cycles++;
      tick("t3.busy");
    end
    check("t3.busy_len", 64'(busy_cycles), 64'd4);
    check("t3.state", 64'(state_o), 64'd2);
    check("t3.err", 64'(err_o), 64'd1);
    check("t3.owner", 64'(owner_o), 64'd2);
    check("t3.err_cnt", 64'(err_cnt_o), 64'd1);
    done_i = 1'b1; req_i = 4'b1111;
    tick("t3.ignore");
    check("t3.still_err", 64'(state_o), 64'd2);
    idle_inputs();
    err_clr_i = 1'b1;
    tick("t3.clr");
    check("t3.idle", 64'(state_o), 64'd0);
    err_clr_i = 1'b0;

    // Timeout 2, done in the second BUSY cycle wins
    timeout_i = 8'd2;
    req_i = 4'b0001;
    tick("t4.grant");
    req_i = '0;
    tick("t4.busy2");
    done_i = 1'b1;
    tick("t4.done");
    check("t4.idle", 64'(state_o), 64'd0);
    check("t4.err_cnt", 64'(err_cnt_o), 64'd1);
    done_i = 1'b0;

    // Watchdog disabled: long stall stays BUSY
    timeout_i = 8'd0;
    req_i = 4'b1000;
    tick("t5.grant");
    req_i = '0;
    for (int c = 0; c < 1000; c++) tick("t5.stall");
    check("t5.busy", 64'(state_o), 64'd1);
    check("t5.noerr", 64'(err_o), 64'd0);
    // Lowering the timeout mid-transaction traps immediately
    timeout_i = 8'd3;
    tick("t5.late_to");
    check("t5.err", 64'(state_o), 64'd2);
    err_clr_i = 1'b1;
    tick("t5.clr");
    err_clr_i = 1'b0;

    // Reset during BUSY with ch1 owner
    req_i = 4'b0010;
    tick("t6.grant");
    check("t6.owner", 64'(owner_o), 64'd1);
    req_i = '0;
    rst_n = 1'b0;
    tick("t6.rst");
    check("t6.state", 64'(state_o), 64'd0);
    check("t6.valid", 64'(bus_valid_o), 64'd0);
    check("t6.data", 64'(bus_data_o), 64'd0);
    check("t6.errcnt", 64'(err_cnt_o), 64'd0);
    rst_n = 1'b1;
    req_i = 4'b0011;
    tick("t6.regrant");
    check("t6.ch0", 64'(gnt_o), 64'h1);
    idle_inputs();

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      req_i     = NCH'($urandom_range(0, (1 << NCH) - 1));
      done_i    = ($urandom_range(0, 3) == 0);
      err_clr_i = ($urandom_range(0, 2) == 0);
      timeout_i = TOW'($urandom_range(0, 6));
      rst_n     = ($urandom_range(0, 149) != 0);
      for (int k = 0; k < NCH; k++) data_i[k*DW +: DW] = $urandom;
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
